// File: rtl/gemm_csr_cmdq_pkg.sv
// Shared types and register map for the GEMM command-queue CSR block.
// The STATUS register at 0x1C exists only when GEMM_CMDQ_STATUS_EN is defined.
package gemm_csr_cmdq_pkg;

  localparam int GEMM_ADDR_W = 32;
  localparam int GEMM_SIZE_W = 5;

  // Byte offsets inside the 32-byte register window.
  localparam logic [4:0] GEMM_OFF_A        = 5'h00;
  localparam logic [4:0] GEMM_OFF_B        = 5'h04;
  localparam logic [4:0] GEMM_OFF_C        = 5'h08;
  localparam logic [4:0] GEMM_OFF_A_STRIDE = 5'h0C;
  localparam logic [4:0] GEMM_OFF_B_STRIDE = 5'h10;
  localparam logic [4:0] GEMM_OFF_CTRL     = 5'h14;
  localparam logic [4:0] GEMM_OFF_DIM      = 5'h18;
  localparam logic [4:0] GEMM_OFF_STAT     = 5'h1C;

  typedef struct packed {
    logic [GEMM_ADDR_W-1:0] a_addr;
    logic [GEMM_ADDR_W-1:0] b_addr;
    logic [GEMM_ADDR_W-1:0] c_addr;
    logic [GEMM_ADDR_W-1:0] a_stride;
    logic [GEMM_ADDR_W-1:0] b_stride;
    logic                   first;
    logic                   last;
    logic [GEMM_SIZE_W-1:0] m_size;
    logic [GEMM_SIZE_W-1:0] k_size;
    logic [GEMM_SIZE_W-1:0] n_size;
  } gemm_cmd_t;

endpackage

// File: rtl/gemm_csr_cmdq_if.sv
// System-bus register port: the host drives the strobe/address/data, the
// responder returns combinational read data.
interface gemm_csr_cmdq_if;
  logic        en;
  logic        rdwr;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output en, rdwr, addr, wr_data, input  rd_data);
  modport slave  (input  en, rdwr, addr, wr_data, output rd_data);
endinterface

// File: rtl/gemm_csr_cmdq_fifo.sv
// Synchronous show-ahead FIFO for tile commands; a push into a full queue is
// accepted only when a pop frees the head slot in the same cycle.
module gemm_cmd_fifo
  import gemm_csr_cmdq_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = gemm_cmd_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wr_data,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   push_ok
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared on reset so the head reads as zero out of reset;
      // this costs a reset net per bit, which is fine at this depth.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gemm_csr_cmdq.sv
// Bus-responder CSR block feeding tile commands to the GEMM engine.
// Optional STATUS register at 0x1C is built when GEMM_CMDQ_STATUS_EN is defined.
module gemm_csr_cmdq
  import gemm_csr_cmdq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = GEMM_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  gemm_csr_cmdq_if.slave  system_bus,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output gemm_cmd_t       cmd,
  input  logic            tile_done
);

  localparam int OUT_W = $clog2(DEPTH) + 2;

  logic              hit;
  logic              wr_hit;
  logic              rd_hit;
  logic [4:0]        off;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr, a_stride, b_stride;
  logic              ctrl_first, ctrl_last;
  logic              push, push_ok, pop;
  logic              q_full, q_empty;
  logic [$clog2(DEPTH):0] q_count;
  logic [OUT_W-1:0]  outstanding;
  logic              done_ok;
  logic              done;
  gemm_cmd_t         push_entry;

  assign hit    = system_bus.en & (system_bus.addr[31:5] == BASE_ADDR[31:5])
                & (system_bus.addr[1:0] == 2'b00);
  assign off    = system_bus.addr[4:0];
  assign wr_hit = hit & system_bus.rdwr;
  assign rd_hit = hit & ~system_bus.rdwr;

  assign push      = wr_hit & (off == GEMM_OFF_DIM);
  assign cmd_valid = ~q_empty;
  assign pop       = cmd_valid & cmd_ready;
  assign done_ok   = tile_done & (outstanding != '0);
  assign done      = (q_count == '0) & (outstanding == '0);

  // Staging registers persist across pushes so a host can resend only what changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_addr     <= '0;
      b_addr     <= '0;
      c_addr     <= '0;
      a_stride   <= '0;
      b_stride   <= '0;
      ctrl_first <= 1'b0;
      ctrl_last  <= 1'b0;
    end else if (wr_hit) begin
      // NOTE: every flop in a clocked block takes <= so all reads see pre-edge values.
      case (off)
        GEMM_OFF_A:        a_addr   <= system_bus.wr_data[ADDR_W-1:0];
        GEMM_OFF_B:        b_addr   <= system_bus.wr_data[ADDR_W-1:0];
        GEMM_OFF_C:        c_addr   <= system_bus.wr_data[ADDR_W-1:0];
        GEMM_OFF_A_STRIDE: a_stride <= system_bus.wr_data[ADDR_W-1:0];
        GEMM_OFF_B_STRIDE: b_stride <= system_bus.wr_data[ADDR_W-1:0];
        GEMM_OFF_CTRL: begin
          ctrl_first <= system_bus.wr_data[1];
          ctrl_last  <= system_bus.wr_data[0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    push_entry.a_addr   = a_addr;
    push_entry.b_addr   = b_addr;
    push_entry.c_addr   = c_addr;
    push_entry.a_stride = a_stride;
    push_entry.b_stride = b_stride;
    push_entry.first    = ctrl_first;
    push_entry.last     = ctrl_last;
    push_entry.n_size   = system_bus.wr_data[14:10];
    push_entry.k_size   = system_bus.wr_data[9:5];
    push_entry.m_size   = system_bus.wr_data[4:0];
  end

  gemm_cmd_fifo #(.DEPTH(DEPTH), .T(gemm_cmd_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .head    (cmd),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count),
    .push_ok (push_ok)
  );

  // Commands issued but not yet retired; a retire with nothing in flight is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({pop, done_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef GEMM_CMDQ_STATUS_EN
  logic       overflow, spurious_done;
  logic [7:0] push_cnt;
  logic       stat_wr;

  assign stat_wr = wr_hit & (off == GEMM_OFF_STAT);

  // Set terms are ORed after the W1C mask so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow      <= 1'b0;
      spurious_done <= 1'b0;
      push_cnt      <= '0;
    end else begin
      overflow      <= (push & ~push_ok)
                     | (overflow & ~(stat_wr & system_bus.wr_data[0]));
      spurious_done <= (tile_done & (outstanding == '0))
                     | (spurious_done & ~(stat_wr & system_bus.wr_data[1]));
      if (push_ok) push_cnt <= push_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    system_bus.rd_data = '0;
    if (rd_hit) begin
      case (off)
        GEMM_OFF_A:   system_bus.rd_data = {31'b0, q_full};
        GEMM_OFF_DIM: system_bus.rd_data = {31'b0, done};
`ifdef GEMM_CMDQ_STATUS_EN
        GEMM_OFF_STAT: system_bus.rd_data = {push_cnt, 8'b0, 8'(q_count),
                                             6'b0, spurious_done, overflow};
`endif
        default:      system_bus.rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_csr_cmdq.sv
// Directed self-checking bench for gemm_csr_cmdq (DEPTH=4); STATUS checks are
// compiled in when GEMM_CMDQ_STATUS_EN is defined.
module tb_gemm_csr_cmdq;
  import gemm_csr_cmdq_pkg::*;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      cmd_ready = 1'b0;
  logic      tile_done = 1'b0;
  logic      cmd_valid;
  gemm_cmd_t cmd;
  int        n_cmp = 0;
  int        n_err = 0;

  gemm_csr_cmdq_if bus ();

  gemm_csr_cmdq #(.BASE_ADDR(BASE), .DEPTH(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .system_bus (bus),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .tile_done  (tile_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.en      = 1'b1;
    bus.rdwr    = 1'b1;
    bus.addr    = addr;
    bus.wr_data = data;
    tick();
    bus.en   = 1'b0;
    bus.rdwr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.en   = 1'b1;
    bus.rdwr = 1'b0;
    bus.addr = addr;
    #1;
    data   = bus.rd_data;
    bus.en = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  task automatic push_dim(input logic [4:0] m, input logic [4:0] k, input logic [4:0] n);
    bus_write(BASE + 32'h18, {17'b0, n, k, m});
  endtask

  task automatic pulse_done();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  exp_m [4];
    bus.en = 1'b0; bus.rdwr = 1'b0; bus.addr = '0; bus.wr_data = '0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_m", 64'(cmd.m_size), 64'd0);
    check_read("rst_full", BASE + 32'h00, 32'd0);
    check_read("rst_done", BASE + 32'h18, 32'd1);
`ifdef GEMM_CMDQ_STATUS_EN
    check_read("rst_stat", BASE + 32'h1C, 32'd0);
`else
    check_read("stat_absent", BASE + 32'h1C, 32'd0);
`endif

    // Single tile
    cmd_ready = 1'b1;
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h04, 32'd496);
    bus_write(BASE + 32'h08, 32'd512);
    bus_write(BASE + 32'h0C, 32'd16);
    bus_write(BASE + 32'h10, 32'd16);
    bus_write(BASE + 32'h14, 32'd3);
    push_dim(5'd16, 5'd16, 5'd16);
    check("t1_valid", 64'(cmd_valid), 64'd1);
    check("t1_a", 64'(cmd.a_addr), 64'd0);
    check("t1_b", 64'(cmd.b_addr), 64'd496);
    check("t1_c", 64'(cmd.c_addr), 64'd512);
    check("t1_as", 64'(cmd.a_stride), 64'd16);
    check("t1_bs", 64'(cmd.b_stride), 64'd16);
    check("t1_first", 64'(cmd.first), 64'd1);
    check("t1_last", 64'(cmd.last), 64'd1);
    check("t1_m", 64'(cmd.m_size), 64'd16);
    check("t1_k", 64'(cmd.k_size), 64'd16);
    check("t1_n", 64'(cmd.n_size), 64'd16);
    tick();
    check("t1_popped", 64'(cmd_valid), 64'd0);
    check_read("t1_busy", BASE + 32'h18, 32'd0);
    cmd_ready = 1'b0;
    pulse_done();
    check_read("t1_done", BASE + 32'h18, 32'd1);

    // Fill to DEPTH, then a dropped 5th push
    for (int i = 1; i <= 4; i++) push_dim(5'(i), 5'(i + 8), 5'(i + 16));
    check_read("fill_full", BASE + 32'h00, 32'd1);
    check("fill_head_m", 64'(cmd.m_size), 64'd1);
    check("fill_reuse_b", 64'(cmd.b_addr), 64'd496);
    push_dim(5'd5, 5'd0, 5'd0);
    check_read("drop_full", BASE + 32'h00, 32'd1);
`ifdef GEMM_CMDQ_STATUS_EN
    bus_read(BASE + 32'h1C, d);
    check("stat_ovf_set", 64'(d[0]), 64'd1);
    check("stat_count", 64'(d[15:8]), 64'd4);
    bus_write(BASE + 32'h1C, 32'd1);
    bus_read(BASE + 32'h1C, d);
    check("stat_ovf_clr", 64'(d[0]), 64'd0);
`endif
    cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_valid%0d", i), 64'(cmd_valid), 64'd1);
      check($sformatf("drain_m%0d", i), 64'(cmd.m_size), 64'(i));
      check($sformatf("drain_n%0d", i), 64'(cmd.n_size), 64'(i + 16));
      tick();
    end
    check("drain_no5th", 64'(cmd_valid), 64'd0);
    cmd_ready = 1'b0;
    repeat (4) pulse_done();
    check_read("drain_done", BASE + 32'h18, 32'd1);

    // Push on a full queue with a concurrent pop
    for (int i = 7; i <= 10; i++) push_dim(5'(i), 5'd0, 5'd0);
    check("cc_head_before", 64'(cmd.m_size), 64'd7);
    cmd_ready = 1'b1;
    push_dim(5'd11, 5'd0, 5'd0);
    cmd_ready = 1'b0;
    check_read("cc_full", BASE + 32'h00, 32'd1);
    exp_m = '{5'd8, 5'd9, 5'd10, 5'd11};
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cc_m%0d", i), 64'(cmd.m_size), 64'(exp_m[i]));
      tick();
    end
    check("cc_empty", 64'(cmd_valid), 64'd0);
    cmd_ready = 1'b0;

    // Reset mid-operation discards queued and in-flight commands
    push_dim(5'd12, 5'd0, 5'd0);
    push_dim(5'd13, 5'd0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 64'(cmd_valid), 64'd0);
    check("mrst_cmd_m", 64'(cmd.m_size), 64'd0);
    check_read("mrst_full", BASE + 32'h00, 32'd0);
    check_read("mrst_done", BASE + 32'h18, 32'd1);

    // Outstanding: 3 pops, then pop + tile_done together, then 3 retires
    for (int i = 1; i <= 4; i++) push_dim(5'(i), 5'd0, 5'd0);
    cmd_ready = 1'b1;
    repeat (3) tick();
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    cmd_ready = 1'b0;
    check("os_valid", 64'(cmd_valid), 64'd0);
    check_read("os_busy0", BASE + 32'h18, 32'd0);
    pulse_done();
    check_read("os_busy1", BASE + 32'h18, 32'd0);
    pulse_done();
    check_read("os_busy2", BASE + 32'h18, 32'd0);
    pulse_done();
    check_read("os_done", BASE + 32'h18, 32'd1);
    pulse_done();
    check_read("os_extra_done", BASE + 32'h18, 32'd1);
`ifdef GEMM_CMDQ_STATUS_EN
    bus_read(BASE + 32'h1C, d);
    check("stat_spur_set", 64'(d[1]), 64'd1);
    bus_write(BASE + 32'h1C, 32'd2);
    bus_read(BASE + 32'h1C, d);
    check("stat_spur_clr", 64'(d[1]), 64'd0);
`endif

    // Decode: out-of-window and misaligned accesses do nothing
    bus_write(32'h9000_0100, 32'h0000_1234);
    bus_write(32'h9000_0118, 32'h0000_001F);
    bus_write(32'h9000_0002, 32'hDEAD_BEEF);
    bus_write(32'h9000_001A, 32'h0000_001F);
    check("dec_valid", 64'(cmd_valid), 64'd0);
    check_read("dec_rd_miss", 32'h9000_0118, 32'd0);
    check_read("dec_rd_misalign", 32'h9000_001A, 32'd0);
    check_read("dec_done", BASE + 32'h18, 32'd1);
    push_dim(5'd3, 5'd2, 5'd1);
    check("dec_push_valid", 64'(cmd_valid), 64'd1);
    check("dec_a_kept", 64'(cmd.a_addr), 64'd0);
    check("dec_first", 64'(cmd.first), 64'd0);
    check("dec_m", 64'(cmd.m_size), 64'd3);
    check("dec_k", 64'(cmd.k_size), 64'd2);
    check("dec_n", 64'(cmd.n_size), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
